// File: rtl/wb_stage_param.sv
// Write-back stage: selects the result source, extends loads and registers the
// register-file write port, with hazard stall/flush, a same-cycle bypass and a retire counter.
module wb_stage_param #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_wb_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   load_data,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [XLEN-1:0]   imm,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        load_funct3,
    input  logic [1:0]        addr_lo,
    input  logic [REG_AW-1:0] rd,
    input  logic              regwrite_en,
    output logic [XLEN-1:0]   wb_id_wd3,
    output logic [REG_AW-1:0] wb_id_rd_a3,
    output logic              wb_id_we3,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_misalign,
    output logic [CNT_W-1:0]  retire_count,
    output logic              retire_pulse
);

    // Handshake: mem_wb_valid qualifies every input on the cycle it is seen; there is
    // no ready, the stage is held only by stall and the captured slot is killed by flush.

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam bit         HAS_LWU = (XLEN == 64);

    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_ext;
    logic [XLEN-1:0] w_sel_data;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_misalign;
    logic            w_fwd_valid;

    logic [XLEN-1:0]   r_wd3;
    logic [REG_AW-1:0] r_a3;
    logic              r_we3;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_count;
    logic              r_pulse;

    assign w_word = load_data[31:0];

    generate
        if (XLEN > 32) begin : g_ld_hi
            logic w_unused_ld_hi;
            assign w_unused_ld_hi = ^load_data[XLEN-1:32];
        end
    endgenerate

    always_comb begin
        w_byte = w_word[7:0];
        case (addr_lo)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = addr_lo[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_ext = '0;
        case (load_funct3)
            F3_LB:  w_load_ext = XLEN'($signed(w_byte));
            F3_LH:  w_load_ext = XLEN'($signed(w_half));
            F3_LW:  w_load_ext = XLEN'($signed(w_word));
            F3_LBU: w_load_ext = XLEN'(w_byte);
            F3_LHU: w_load_ext = XLEN'(w_half);
            F3_LWU: w_load_ext = HAS_LWU ? XLEN'(w_word) : '0;
            default: w_load_ext = '0;
        endcase
    end

    // LWU is only a real load on 64-bit builds, so only there can it be misaligned.
    assign w_is_half  = (load_funct3 == F3_LH) || (load_funct3 == F3_LHU);
    assign w_is_word  = (load_funct3 == F3_LW) || (HAS_LWU && (load_funct3 == F3_LWU));
    assign w_misalign = (wb_sel == 2'b01) &&
                        ((w_is_half && addr_lo[0]) || (w_is_word && (addr_lo != 2'b00)));

    always_comb begin
        w_sel_data = alu_out;
        case (wb_sel)
            2'b00: w_sel_data = alu_out;
            2'b01: w_sel_data = w_load_ext;
            2'b10: w_sel_data = pc_plus4;
            2'b11: w_sel_data = imm;
            default: w_sel_data = alu_out;
        endcase
    end

    assign w_fwd_valid = mem_wb_valid && regwrite_en && (rd != '0) && !w_misalign && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd3      <= '0;
            r_a3       <= '0;
            r_we3      <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
            r_pulse    <= 1'b0;
        end else if (flush) begin
            r_we3      <= 1'b0;
            r_misalign <= 1'b0;
            r_pulse    <= 1'b0;
        end else if (stall) begin
            r_pulse    <= 1'b0;
        end else begin
            r_wd3      <= w_sel_data;
            r_a3       <= rd;
            r_we3      <= w_fwd_valid;
            r_misalign <= mem_wb_valid && w_misalign;
            r_pulse    <= mem_wb_valid;
            r_count    <= r_count + CNT_W'(mem_wb_valid);
        end
    end

    assign fwd_valid     = w_fwd_valid;
    assign fwd_rd        = rd;
    assign fwd_data      = w_sel_data;
    assign wb_id_wd3     = r_wd3;
    assign wb_id_rd_a3   = r_a3;
    assign wb_id_we3     = r_we3;
    assign load_misalign = r_misalign;
    assign retire_count  = r_count;
    assign retire_pulse  = r_pulse;

endmodule

// File: tb/tb_wb_stage_param.sv
// Bench for wb_stage_param: directed vectors into a scoreboard queue checked by a
// monitor one edge later, plus a 64-bit / 4-bit-counter instance for LWU and wrap.
module tb_wb_stage_param;

    logic        clk;
    logic        rst_n;

    logic        mem_wb_valid, stall, flush, regwrite_en;
    logic [31:0] alu_out, load_data, pc_plus4, imm;
    logic [1:0]  wb_sel, addr_lo;
    logic [2:0]  load_funct3;
    logic [4:0]  rd;
    logic [31:0] wb_id_wd3, fwd_data, retire_count;
    logic [4:0]  wb_id_rd_a3, fwd_rd;
    logic        wb_id_we3, fwd_valid, load_misalign, retire_pulse;

    logic        v64, rw64;
    logic [63:0] alu64, ld64, pc64, imm64;
    logic [1:0]  sel64;
    logic [2:0]  f3_64;
    logic [4:0]  rd64;
    logic [63:0] wd3_64, fwd_data64;
    logic [4:0]  a3_64, fwd_rd64;
    logic        we3_64, fwd_valid64, mis64, pulse64;
    logic [3:0]  cnt64;

    int n_cmp  = 0;
    int n_fail = 0;

    // {wd3[31:0], a3[4:0], we3, misalign, pulse, count[31:0]}
    logic [71:0] exp_q[$];

    logic [31:0] m_wd3 = '0;
    logic [4:0]  m_a3  = '0;
    logic        m_we3 = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_cnt = '0;

    wb_stage_param #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_wb_valid(mem_wb_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .load_data(load_data), .pc_plus4(pc_plus4), .imm(imm),
        .wb_sel(wb_sel), .load_funct3(load_funct3), .addr_lo(addr_lo), .rd(rd),
        .regwrite_en(regwrite_en), .wb_id_wd3(wb_id_wd3), .wb_id_rd_a3(wb_id_rd_a3),
        .wb_id_we3(wb_id_we3), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_misalign(load_misalign), .retire_count(retire_count), .retire_pulse(retire_pulse)
    );

    wb_stage_param #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .mem_wb_valid(v64), .stall(1'b0), .flush(1'b0),
        .alu_out(alu64), .load_data(ld64), .pc_plus4(pc64), .imm(imm64),
        .wb_sel(sel64), .load_funct3(f3_64), .addr_lo(2'b00), .rd(rd64),
        .regwrite_en(rw64), .wb_id_wd3(wd3_64), .wb_id_rd_a3(a3_64),
        .wb_id_we3(we3_64), .fwd_valid(fwd_valid64), .fwd_rd(fwd_rd64), .fwd_data(fwd_data64),
        .load_misalign(mis64), .retire_count(cnt64), .retire_pulse(pulse64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: registered outputs appear one edge after the vector was driven.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            logic [71:0] e;
            e = exp_q.pop_front();
            chk("wd3",      64'(wb_id_wd3),     64'(e[71:40]));
            chk("a3",       64'(wb_id_rd_a3),   64'(e[39:35]));
            chk("we3",      64'(wb_id_we3),     64'(e[34]));
            chk("misalign", 64'(load_misalign), 64'(e[33]));
            chk("pulse",    64'(retire_pulse),  64'(e[32]));
            chk("count",    64'(retire_count),  64'(e[31:0]));
        end
    end

    // e_wd3/e_we3/e_mis are the hand values for this vector's own result;
    // hold/kill effects of stall and flush are applied here.
    task automatic apply(input logic v, input logic st, input logic fl, input logic [1:0] sel,
                         input logic [31:0] data, input logic [2:0] f3, input logic [1:0] al,
                         input logic [4:0] r, input logic rw, input logic [31:0] e_wd3,
                         input logic e_we3, input logic e_mis);
        logic pulse;
        @(negedge clk);
        mem_wb_valid = v; stall = st; flush = fl; wb_sel = sel;
        alu_out  = (sel == 2'b00) ? data : $urandom;
        load_data = (sel == 2'b01) ? data : $urandom;
        pc_plus4 = (sel == 2'b10) ? data : $urandom;
        imm      = (sel == 2'b11) ? data : $urandom;
        load_funct3 = f3; addr_lo = al; rd = r; regwrite_en = rw;
        #1;
        chk("fwd_data",  64'(fwd_data),  64'(e_wd3));
        chk("fwd_rd",    64'(fwd_rd),    64'(r));
        chk("fwd_valid", 64'(fwd_valid), 64'(e_we3 && !fl));
        pulse = 1'b0;
        if (fl) begin
            m_we3 = 1'b0; m_mis = 1'b0;
        end else if (!st) begin
            m_wd3 = e_wd3; m_a3 = r; m_we3 = e_we3; m_mis = v && e_mis;
            pulse = v; m_cnt = m_cnt + 32'(v);
        end
        exp_q.push_back({m_wd3, m_a3, m_we3, m_mis, pulse, m_cnt});
    endtask

    task automatic step64(input logic v, input logic [1:0] sel, input logic [63:0] data,
                          input logic [2:0] f3);
        @(negedge clk);
        v64 = v; sel64 = sel; f3_64 = f3; rd64 = 5'd7; rw64 = 1'b1;
        alu64 = data; ld64 = data; pc64 = 64'h0; imm64 = 64'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_wb_valid = 0; stall = 0; flush = 0; regwrite_en = 0;
        alu_out = 0; load_data = 0; pc_plus4 = 0; imm = 0;
        wb_sel = 0; addr_lo = 0; load_funct3 = 0; rd = 0;
        v64 = 0; rw64 = 0; alu64 = 0; ld64 = 0; pc64 = 0; imm64 = 0;
        sel64 = 0; f3_64 = 0; rd64 = 0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_wb_valid = 1'($urandom_range(0, 1)); regwrite_en = 1'b1;
            alu_out = $urandom; load_data = $urandom; wb_sel = 2'($urandom_range(0, 3));
            rd = 5'($urandom_range(1, 31));
        end
        @(posedge clk); #1;
        chk("rst_wd3",   64'(wb_id_wd3),     64'h0);
        chk("rst_a3",    64'(wb_id_rd_a3),   64'h0);
        chk("rst_we3",   64'(wb_id_we3),     64'h0);
        chk("rst_mis",   64'(load_misalign), 64'h0);
        chk("rst_cnt",   64'(retire_count),  64'h0);
        chk("rst_pulse", 64'(retire_pulse),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //    v  st fl sel    data          f3    al   rd  rw  exp_wd3        we mis
        apply(1, 0, 0, 2'b00, 32'h00000005, 3'd0, 2'd0, 3, 1, 32'h00000005, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd0, 2'd3, 4, 1, 32'hFFFFFF80, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd4, 2'd1, 6, 1, 32'h0000007F, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd4, 2'd2, 7, 1, 32'h000000FF, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd1, 2'd2, 8, 1, 32'hFFFF80FF, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd5, 2'd0, 9, 1, 32'h00007F01, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd2, 2'd1, 5, 1, 32'h80FF7F01, 0, 1);
        apply(1, 0, 0, 2'b00, 32'h00001234, 3'd0, 2'd0, 0, 1, 32'h00001234, 0, 0);
        apply(1, 0, 0, 2'b11, 32'hABCDE000, 3'd0, 2'd0, 10, 1, 32'hABCDE000, 1, 0);
        apply(1, 1, 0, 2'b00, 32'h11111111, 3'd0, 2'd0, 11, 1, 32'h11111111, 1, 0);
        apply(1, 1, 0, 2'b00, 32'h22222222, 3'd0, 2'd0, 12, 1, 32'h22222222, 1, 0);
        apply(1, 1, 0, 2'b00, 32'h33333333, 3'd0, 2'd0, 13, 1, 32'h33333333, 1, 0);
        apply(1, 1, 1, 2'b00, 32'h44444444, 3'd0, 2'd0, 14, 1, 32'h44444444, 1, 0);
        apply(1, 0, 0, 2'b10, 32'h00000104, 3'd0, 2'd0, 1, 1, 32'h00000104, 1, 0);
        apply(1, 0, 1, 2'b10, 32'h00000104, 3'd0, 2'd0, 1, 1, 32'h00000104, 1, 0);
        apply(0, 0, 0, 2'b00, 32'h00000055, 3'd0, 2'd0, 2, 1, 32'h00000055, 0, 0);
        apply(1, 0, 0, 2'b00, 32'h00000066, 3'd0, 2'd0, 3, 0, 32'h00000066, 0, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd1, 2'd1, 15, 1, 32'h00007F01, 0, 1);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd3, 2'd0, 12, 1, 32'h00000000, 1, 0);
        apply(1, 0, 0, 2'b01, 32'h80FF7F01, 3'd6, 2'd0, 13, 1, 32'h00000000, 1, 0);
        apply(1, 0, 0, 2'b00, 32'hCAFEF00D, 3'd0, 2'd0, 31, 1, 32'hCAFEF00D, 1, 0);

        @(negedge clk);
        mem_wb_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        // Asynchronous reset in the middle of a cycle clears state immediately.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wd3",   64'(wb_id_wd3),    64'h0);
        chk("mid_rst_we3",   64'(wb_id_we3),    64'h0);
        chk("mid_rst_cnt",   64'(retire_count), 64'h0);
        chk("mid_rst_pulse", 64'(retire_pulse), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) step64(1'b1, 2'b00, 64'(i), 3'd0);
        chk("wrap16_cnt", 64'(cnt64), 64'h0);
        step64(1'b1, 2'b00, 64'h0123456789ABCDEF, 3'd0);
        chk("wrap17_cnt", 64'(cnt64), 64'h1);
        chk("alu64_wd3",  wd3_64,     64'h0123456789ABCDEF);
        step64(1'b1, 2'b01, 64'hDEADBEEF80000000, 3'd6);
        chk("lwu64_wd3",  wd3_64,     64'h0000000080000000);
        chk("lwu64_we3",  64'(we3_64), 64'h1);
        step64(1'b1, 2'b01, 64'hDEADBEEF80000000, 3'd2);
        chk("lw64_wd3",   wd3_64,     64'hFFFFFFFF80000000);
        step64(1'b0, 2'b00, 64'h5, 3'd0);
        chk("bubble64_cnt", 64'(cnt64), 64'h3);
        chk("bubble64_we3", 64'(we3_64), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
